// File: rtl/processor_pkg.sv
// Shared processor definitions used by the multiply/accumulate engine.
// Contents: multiply opcode encodings, engine state encoding, CPSR N/Z bit
// positions, and small opcode-decode helpers.
package processor_pkg;

    localparam logic [3:0] OP_MUL   = 4'b0000;
    localparam logic [3:0] OP_MLA   = 4'b0001;
    localparam logic [3:0] OP_UMULL = 4'b0100;
    localparam logic [3:0] OP_UMLAL = 4'b0101;
    localparam logic [3:0] OP_SMULL = 4'b0110;
    localparam logic [3:0] OP_SMLAL = 4'b0111;

    // Flag positions in the CPSR, shared with the writeback path
    localparam int unsigned CPSR_N_BIT = 31;
    localparam int unsigned CPSR_Z_BIT = 30;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULTIPLY,
        ST_ACCUMULATE,
        ST_DONE
    } mac_state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_MUL, OP_MLA, OP_UMULL, OP_UMLAL, OP_SMULL, OP_SMLAL: op_is_legal = 1'b1;
            default:                                               op_is_legal = 1'b0;
        endcase
    endfunction

    // smull/smlal share the 011x encoding
    function automatic logic op_is_signed(input logic [3:0] op);
        op_is_signed = (op[3:1] == 3'b011);
    endfunction

    // Long forms (umull/umlal/smull/smlal) have opcode bit 2 set
    function automatic logic op_is_long(input logic [3:0] op);
        op_is_long = op[2];
    endfunction

    // Accumulating forms have opcode bit 0 set
    function automatic logic op_is_acc(input logic [3:0] op);
        op_is_acc = op[0];
    endfunction

endpackage

// File: rtl/multiply_accumulate_unit_multiply_step.sv
// multiply_step: combinational radix-2^BITS_PER_CYCLE partial-product adder.
// Ports:
//   partial      in  2*WIDTH  running partial product
//   multiplicand in  WIDTH    unsigned multiplicand
//   b_slice      in  BPC      current multiplier digit
//   shift        in  log2(W)  bit weight of the current digit
//   next_partial out 2*WIDTH  partial + (multiplicand * b_slice) << shift
module multiply_step #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 2
) (
    input  logic [2*WIDTH-1:0]         partial,
    input  logic [WIDTH-1:0]           multiplicand,
    input  logic [BITS_PER_CYCLE-1:0]  b_slice,
    input  logic [$clog2(WIDTH)-1:0]   shift,
    output logic [2*WIDTH-1:0]         next_partial
);

    logic [WIDTH+BITS_PER_CYCLE-1:0] digit_product;

    always_comb begin
        digit_product = {{BITS_PER_CYCLE{1'b0}}, multiplicand}
                      * {{WIDTH{1'b0}}, b_slice};
        next_partial  = partial
                      + ({{(WIDTH-BITS_PER_CYCLE){1'b0}}, digit_product} << shift);
    end

endmodule

// File: rtl/multiply_accumulate_unit.sv
// multiply_accumulate_unit: iterative mul/mla/umull/umlal/smull/smlal engine
// retiring BITS_PER_CYCLE multiplier bits per clock.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start_valid/start_ready     issue handshake (ready only in IDLE)
//   opcode, a, b                operation, multiplicand (rm), multiplier (rs)
//   acc_hi, acc_lo              accumulator words
//   result_valid/result_ready   result handshake
//   result, n_flag, z_flag      2*WIDTH result and writeback flags
//   illegal                     last operation had an unsupported opcode
//   busy                        engine not in IDLE
// Build option: define EARLY_TERMINATION_EN to leave MULTIPLY as soon as the
// remaining multiplier bits are all zero.
module multiply_accumulate_unit
    import processor_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [3:0]           opcode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     acc_hi,
    input  logic [WIDTH-1:0]     acc_lo,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 n_flag,
    output logic                 z_flag,
    output logic                 illegal,
    output logic                 busy
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_SHIFT = SHW'(WIDTH - BITS_PER_CYCLE);
    localparam logic [SHW-1:0] SHIFT_STEP = SHW'(BITS_PER_CYCLE);

    mac_state_t         state;
    logic [3:0]         op_r;
    logic               illegal_r;
    logic               sign_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   acc_hi_r;
    logic [WIDTH-1:0]   acc_lo_r;
    logic [SHW-1:0]     shift_r;
    logic [2*WIDTH-1:0] partial_r;
    logic [2*WIDTH-1:0] partial_next;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               last_step;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] sum;
    logic [2*WIDTH-1:0] acc_result;
    logic               acc_n;
    logic               acc_z;

    multiply_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .partial      (partial_r),
        .multiplicand (mcand_r),
        .b_slice      (mplier_r[BITS_PER_CYCLE-1:0]),
        .shift        (shift_r),
        .next_partial (partial_next)
    );

    always_comb begin
        a_abs = a[WIDTH-1] ? ('0 - a) : a;
        b_abs = b[WIDTH-1] ? ('0 - b) : b;

`ifdef EARLY_TERMINATION_EN
        last_step = (shift_r == LAST_SHIFT)
                 || (mplier_r[WIDTH-1:BITS_PER_CYCLE] == '0);
`else
        last_step = (shift_r == LAST_SHIFT);
`endif

        prod = sign_r ? ('0 - partial_r) : partial_r;
        sum  = '0;
        if (op_is_long(op_r)) begin
            sum        = prod + {acc_hi_r, acc_lo_r};
            acc_result = op_is_acc(op_r) ? sum : prod;
        end else begin
            sum        = prod + {{WIDTH{1'b0}}, acc_lo_r};
            acc_result = op_is_acc(op_r) ? {{WIDTH{1'b0}}, sum[WIDTH-1:0]}
                                         : {{WIDTH{1'b0}}, prod[WIDTH-1:0]};
        end

        if (op_is_long(op_r)) begin
            acc_n = acc_result[2*WIDTH-1];
            acc_z = (acc_result == '0);
        end else begin
            acc_n = acc_result[WIDTH-1];
            acc_z = (acc_result[WIDTH-1:0] == '0);
        end

        // Illegal opcodes report a zero result with Z set
        if (illegal_r) begin
            acc_result = '0;
            acc_n      = 1'b0;
            acc_z      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            start_ready  <= 1'b1;
            result_valid <= 1'b0;
            result       <= '0;
            n_flag       <= 1'b0;
            z_flag       <= 1'b0;
            illegal      <= 1'b0;
            busy         <= 1'b0;
            op_r         <= OP_MUL;
            illegal_r    <= 1'b0;
            sign_r       <= 1'b0;
            mcand_r      <= '0;
            mplier_r     <= '0;
            acc_hi_r     <= '0;
            acc_lo_r     <= '0;
            shift_r      <= '0;
            partial_r    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        op_r        <= opcode;
                        acc_hi_r    <= acc_hi;
                        acc_lo_r    <= acc_lo;
                        partial_r   <= '0;
                        shift_r     <= '0;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        if (op_is_signed(opcode)) begin
                            mcand_r  <= a_abs;
                            mplier_r <= b_abs;
                            sign_r   <= a[WIDTH-1] ^ b[WIDTH-1];
                        end else begin
                            mcand_r  <= a;
                            mplier_r <= b;
                            sign_r   <= 1'b0;
                        end
                        // Illegal opcodes skip MULTIPLY; ACCUMULATE forces the
                        // zero result so DONE is reached one edge after accept.
                        illegal_r <= !op_is_legal(opcode);
                        state     <= op_is_legal(opcode) ? ST_MULTIPLY : ST_ACCUMULATE;
                    end
                end

                ST_MULTIPLY: begin
                    partial_r <= partial_next;
                    mplier_r  <= mplier_r >> BITS_PER_CYCLE;
                    shift_r   <= shift_r + SHIFT_STEP;
                    if (last_step) begin
                        state <= ST_ACCUMULATE;
                    end
                end

                ST_ACCUMULATE: begin
                    result       <= acc_result;
                    n_flag       <= acc_n;
                    z_flag       <= acc_z;
                    illegal      <= illegal_r;
                    result_valid <= 1'b1;
                    state        <= ST_DONE;
                end

                ST_DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        start_ready  <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
